// File: rtl/video_stream_framer.sv
// Tags a raw, sideband-free pixel stream with AXI4-Stream video sideband (tuser = start of frame, tlast = end of line).
// Latency: 1 cycle from raw accept to output_frame_tvalid when empty; sustains 1 pixel/cycle.
// Backpressure: 2-entry skid buffer; raw_tready is registered and drops only while both entries hold pixels.
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   raw_t{data,valid,ready} untagged input pixel stream
//   resync                  strobe: next accepted pixel restarts the frame geometry
//   output_frame_t*         framed AXI4-Stream video output
//   frame_count             number of completed frames (wraps)
module video_stream_framer #(
  parameter int TDATA_WIDTH  = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [TDATA_WIDTH-1:0] raw_tdata,
  input  logic                   raw_tvalid,
  output logic                   raw_tready,
  input  logic                   resync,
  output logic                   output_frame_tvalid,
  output logic [TDATA_WIDTH-1:0] output_frame_tdata,
  output logic                   output_frame_tuser,
  output logic                   output_frame_tlast,
  input  logic                   output_frame_tready,
  output logic [31:0]            frame_count
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] dat;
    logic                   usr;
    logic                   lst;
  } pix_t;

  localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] x_q, x_d;
  logic [CNT_WIDTH-1:0] y_q, y_d;
  logic                 pend_q, pend_d;
  logic [31:0]          fc_q, fc_d;
  logic                 rdy_q, rdy_d;
  pix_t                 out_q, out_d;
  pix_t                 skd_q, skd_d;

  logic                 accept;
  logic                 do_resync;
  pix_t                 in_pix;

  assign accept    = raw_tvalid & rdy_q;
  // A resync strobe arriving together with a pixel applies to that same pixel.
  assign do_resync = resync | pend_q;

  // Sideband tags for the pixel being accepted this cycle.
  always_comb begin
    in_pix.dat = raw_tdata;
    in_pix.usr = do_resync | ((x_q == '0) && (y_q == '0));
    // FRAME_WIDTH >= 2, so a resynced pixel (x forced to 0) is never end of line.
    in_pix.lst = ~do_resync & (x_q == X_LAST);
  end

  // Geometry counters, resync pending flag and frame counter.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    pend_d = pend_q;
    fc_d   = fc_q;
    if (accept) begin
      if (do_resync) begin
        // The resynced pixel occupies x=0,y=0; the truncated frame is not counted.
        x_d    = CNT_WIDTH'(1);
        y_d    = '0;
        pend_d = 1'b0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fc_d = fc_q + 32'd1;
        end else begin
          y_d = y_q + CNT_WIDTH'(1);
        end
      end else begin
        x_d = x_q + CNT_WIDTH'(1);
      end
    end else if (resync) begin
      pend_d = 1'b1;
    end
  end

  // Skid buffer control: out_q feeds the port, skd_q absorbs the one pixel
  // that can arrive in the cycle the downstream stalls.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_pix;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && !output_frame_tready) begin
          skd_d   = in_pix;
          state_d = FULL;
        end else if (!accept && output_frame_tready) begin
          state_d = EMPTY;
        end else if (accept && output_frame_tready) begin
          out_d = in_pix;
        end
      end
      FULL: begin
        if (output_frame_tready) begin
          out_d   = skd_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      x_q     <= '0;
      y_q     <= '0;
      pend_q  <= 1'b0;
      fc_q    <= '0;
      rdy_q   <= 1'b0;
      out_q   <= '0;
      skd_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      fc_q    <= fc_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
    end
  end

  assign raw_tready          = rdy_q;
  assign output_frame_tvalid = (state_q != EMPTY);
  assign output_frame_tdata  = out_q.dat;
  assign output_frame_tuser  = out_q.usr;
  assign output_frame_tlast  = out_q.lst;
  assign frame_count         = fc_q;

endmodule
